// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : 16x-oversampled 8N1 UART receiver with one-entry holding register
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int CLK_DIV = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            rd_en,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun_err
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [SW-1:0] S_MID    = SW'(7);
  localparam logic [SW-1:0] S_BIT    = SW'(15);
  localparam logic [SW-1:0] S_STOP   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic            rx_meta, rx_s, rx_s_d;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [1:0]      state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            commit, frame_fault;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || tick) div_cnt <= '0;
    else                div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    unique case (state)
      IDLE: begin
        if (rx_s_d && !rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            s_next = '0;
            n_next = '0;
            // Line high again at mid-start-bit means it was a glitch
            state_next = rx_s ? IDLE : DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_next = '0;
            b_next = DBIT'({rx_s, b} >> 1);
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    commit      = 1'b0;
    frame_fault = 1'b0;
    if (state == STOP && tick && s == S_STOP) begin
      commit      = rx_s;
      frame_fault = !rx_s;
    end
  end

  // A commit takes priority over a same-cycle read, so the new byte stays valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout         <= '0;
      rx_valid     <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_done_tick <= commit;
      frame_err    <= frame_fault;
      overrun_err  <= commit && rx_valid && !rd_en;
      if (commit) begin
        dout     <= b;
        rx_valid <= 1'b1;
      end else if (rd_en) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx at CLK_DIV=4
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       manual_rd = 1'b0;
  logic       auto_read = 1'b0;
  logic       sim_read = 1'b0;
  logic       rd_en;
  logic [7:0] dout;
  logic       rx_valid, rx_done_tick, frame_err, overrun_err;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int long_pulse = 0;
  logic prev_done = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16), .CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rd_en        (rd_en),
    .dout         (dout),
    .rx_valid     (rx_valid),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err)
  );

  // sim_read lands a read exactly on the commit cycle
  assign rd_en = manual_rd | (auto_read & rx_valid) | (sim_read & dut.commit);

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      got_q.push_back(dout);
    end
    if (frame_err === 1'b1)   ferr_cnt <= ferr_cnt + 1;
    if (overrun_err === 1'b1) ovr_cnt  <= ovr_cnt + 1;
    if ((rx_done_tick === 1'b1 && prev_done === 1'b1) ||
        (frame_err === 1'b1 && prev_ferr === 1'b1) ||
        (overrun_err === 1'b1 && prev_ovr === 1'b1))
      long_pulse <= long_pulse + 1;
    prev_done <= rx_done_tick;
    prev_ferr <= frame_err;
    prev_ovr  <= overrun_err;
  end

  // Called and returns at a negedge, so consecutive calls leave no idle gap
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic read_byte;
    manual_rd = 1'b1;
    @(negedge clk);
    manual_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_vec++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_vec++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", overrun_err); end
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_single;
    int d0, lat;
    d0 = done_cnt;
    send_byte(8'h55, 1'b1);
    lat = done_cyc - start_cyc;
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL single_done_cnt: got %0d want %0d", done_cnt - d0, 1); end
    n_vec++; if (dout !== 8'h55) begin n_err++; $display("FAIL single_dout: got %h want 55", dout); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    n_vec++; if (lat < 600 || lat > 616) begin n_err++; $display("FAIL single_latency: got %0d want 608+-8", lat); end
    manual_rd = 1'b1;
    @(negedge clk);
    manual_rd = 1'b0;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_rd_clear: got %b want 0", rx_valid); end
    n_vec++; if (dout !== 8'h55) begin n_err++; $display("FAIL single_dout_hold: got %h want 55", dout); end
  endtask

  task automatic test_back_to_back;
    int f0, o0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hAA; exp_b[1] = 8'hFF; exp_b[2] = 8'h00;
    f0 = ferr_cnt; o0 = ovr_cnt;
    got_q.delete();
    auto_read = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
    repeat (BIT) @(negedge clk);
    auto_read = 1'b0;
    n_vec++; if (got_q.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        n_vec++; if (got_q[i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_b[i]); end
      end
    end
    n_vec++; if (ferr_cnt !== f0) begin n_err++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0); end
    n_vec++; if (ovr_cnt !== o0) begin n_err++; $display("FAIL b2b_ovr: got %0d want 0", ovr_cnt - o0); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    rx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    send_byte(8'h3C, 1'b1);
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL glitch_next_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (dout !== 8'h3C) begin n_err++; $display("FAIL glitch_next_dout: got %h want 3c", dout); end
  endtask

  // Enters with 0x3C still unread so the frame error must leave it intact
  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b0);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    n_vec++; if (ferr_cnt !== f0 + 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL ferr_done: got %0d want 0", done_cnt - d0); end
    n_vec++; if (dout !== 8'h3C) begin n_err++; $display("FAIL ferr_dout_hold: got %h want 3c", dout); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ferr_valid_hold: got %b want 1", rx_valid); end
    read_byte();
    send_byte(8'h5A, 1'b1);
    n_vec++; if (dout !== 8'h5A) begin n_err++; $display("FAIL ferr_recover_dout: got %h want 5a", dout); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ferr_recover_valid: got %b want 1", rx_valid); end
    n_vec++; if (ferr_cnt !== f0 + 1) begin n_err++; $display("FAIL ferr_recover_count: got %0d want 1", ferr_cnt - f0); end
    read_byte();
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    n_vec++; if (ovr_cnt !== o0 + 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0); end
    n_vec++; if (dout !== 8'h22) begin n_err++; $display("FAIL ovr_dout: got %h want 22", dout); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    sim_read = 1'b1;
    send_byte(8'h33, 1'b1);
    sim_read = 1'b0;
    n_vec++; if (ovr_cnt !== o0 + 1) begin n_err++; $display("FAIL ovr_rd_same_cycle: got %0d want 1", ovr_cnt - o0); end
    n_vec++; if (dout !== 8'h33) begin n_err++; $display("FAIL ovr_rd_dout: got %h want 33", dout); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_rd_valid: got %b want 1", rx_valid); end
    read_byte();
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    fork
      send_byte(8'h77, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL rstmid_done: got %0d want 0", done_cnt - d0); end
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL rstmid_dout: got %h want 00", dout); end
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
    // The tail of the cut frame can itself look like a start edge; let it drain
    repeat (10 * BIT) @(negedge clk);
    if (rx_valid === 1'b1) read_byte();
    d0 = done_cnt;
    send_byte(8'h81, 1'b1);
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL rstmid_next_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (dout !== 8'h81) begin n_err++; $display("FAIL rstmid_next_dout: got %h want 81", dout); end
    n_vec++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_next_valid: got %b want 1", rx_valid); end
    read_byte();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    n_vec++; if (long_pulse !== 0) begin n_err++; $display("FAIL pulse_width: got %0d long pulses want 0", long_pulse); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
